matriz_loader: RTL
==================

MATRIZ_LOADER -- requirements
Module: matriz_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'd0: RAM address of the first word written.
REQ-002 Parameter NUM_WORDS, default 2: 256-bit words per load (word 0 = matrix A, word 1 = scalar); legal range 1..255-BASE_ADDR.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  byte stream from host.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_last  input  1  qualified by in_valid; marks the final byte of the current word.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 restart  input  1  begins a new load from DONE.
REQ-010 ram_address  output  8  RAM single-port address.
REQ-011 ram_data  output  256  RAM write data.
REQ-012 ram_wren  output  1  RAM write enable.
REQ-013 load_done  output  1  level; all NUM_WORDS words written.
REQ-014 chk_err  output  1  one-cycle pulse on checksum mismatch; constant 0 when LOADER_CHECKSUM_EN is undefined.

Function
REQ-015 States: FILL, CHK (present only with LOADER_CHECKSUM_EN), WRITE, DONE; all outputs registered.
REQ-016 A byte is accepted only when in_valid && in_ready; in_ready = 1 exactly in FILL and CHK.
REQ-017 The k-th accepted byte of a word (k = 0..31) goes to buffer bits [8k+7:8k]; byte 0 is the LSB.
REQ-018 The word ends on the 32nd byte, or on an earlier byte with in_last=1; unfilled bytes are zero. in_last on the 32nd byte has no extra effect.
REQ-019 FILL to WRITE (or to CHK with the macro) on the cycle after the word-ending byte is accepted.
REQ-020 WRITE lasts exactly one cycle, with ram_wren=1, ram_address=BASE_ADDR+word_idx and ram_data=buffer.
REQ-021 After WRITE:
- if word_idx == NUM_WORDS-1: go to DONE and set load_done=1;
- otherwise: word_idx+1, buffer and byte count cleared, go to FILL.
REQ-022 Latency: last byte accepted at cycle T gives ram_wren at T+1 and in_ready=1 again at T+2 (no macro).
REQ-023 Outside WRITE: ram_wren=0; ram_address holds BASE_ADDR+word_idx; ram_data holds the buffer.
REQ-024 DONE: in_ready=0 and load_done=1. restart=1 gives word_idx=0, buffer and byte count cleared, load_done=0, and next state FILL.
REQ-025 restart is ignored outside DONE. in_last without in_valid is ignored. in_valid while in_ready=0 is not consumed; the host holds the byte.
REQ-026 word_idx never wraps; NUM_WORDS=1 goes straight from the first WRITE to DONE.

Reset
REQ-027 rst=1 at a clock edge gives:
- state FILL, word_idx=0, byte count 0, buffer 0;
- ram_wren=0, ram_address=BASE_ADDR, ram_data=0;
- load_done=0, chk_err=0, in_ready=0.
in_ready becomes 1 on the first edge with rst=0.
REQ-028 rst takes priority over every other input, including restart and an in-progress WRITE. A partial word is discarded and never written.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined: after the word-ending byte, the loader enters CHK and accepts exactly one checksum byte. That byte must equal the XOR of all 32 buffer bytes (zero fill included).
- Match: go to WRITE on the next cycle.
- Mismatch: no write; chk_err=1 for one cycle; buffer and byte count cleared; return to FILL with word_idx unchanged.
REQ-030 Macro undefined: CHK state and checksum logic are absent; chk_err is tied 0; the behaviour of REQ-019/022 applies.

Verification
REQ-031 NUM_WORDS=2, no macro; send bytes 0x01..0x20, then 32 bytes of 0x03 -> two write cycles: addr 0 data = {0x20,...,0x02,0x01}, then addr 1 data = {32{0x03}}; load_done=1 the cycle after the second write.
REQ-032 Send 0x05 with in_last=1 as the first byte of word 1 -> addr 1 data = 256'h05; byte-to-wren latency is 1 cycle.
REQ-033 Hold in_valid=1 continuously through the load -> at most 32 bytes consumed per word; in_ready=0 in the WRITE cycle and in DONE; no byte is lost or duplicated.
REQ-034 Assert rst after 10 bytes of word 0 -> no ram_wren pulse; a fresh 64-byte load then writes addr 0 from its first byte onward.
REQ-035 In DONE, pulse restart together with in_valid=1 -> that byte is not accepted; load_done=0 on the next cycle; the next load writes addr BASE_ADDR again.
REQ-036 With LOADER_CHECKSUM_EN: send 32 bytes of 0x11 then checksum 0x01 -> chk_err pulse and no write; resend 32 bytes of 0x11 then 0x00 -> write to addr 0 (XOR of 32 equal bytes is 0x00).

Source files
------------

// File: rtl/matriz_loader.sv
// matriz_loader
// Collects a stream of host bytes into 256-bit words and writes each
// finished word to a single-port RAM at consecutive addresses starting
// at BASE_ADDR. After NUM_WORDS words the loader parks in DONE until
// restart is pulsed.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, every word is followed by one checksum byte that must
//   equal the XOR of all 32 buffer bytes; a mismatch drops the word and
//   pulses chk_err. When undefined, chk_err is tied low.
//
// Ports
//   clk          in   1    single clock, posedge
//   rst          in   1    synchronous active-high reset
//   in_data      in   8    host byte
//   in_valid     in   1    in_data valid this cycle
//   in_last      in   1    final byte of the current word (with in_valid)
//   in_ready     out  1    loader accepts a byte this cycle
//   restart      in   1    start a new load from DONE
//   ram_address  out  8    RAM address (BASE_ADDR + word index)
//   ram_data     out  256  RAM write data (the word buffer)
//   ram_wren     out  1    RAM write enable, one cycle per word
//   load_done    out  1    level, all words written
//   chk_err      out  1    one-cycle pulse on checksum mismatch
module matriz_loader #(
  parameter logic [7:0] BASE_ADDR = 8'd0,
  parameter int         NUM_WORDS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         restart,
  output logic [7:0]   ram_address,
  output logic [255:0] ram_data,
  output logic         ram_wren,
  output logic         load_done,
  output logic         chk_err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {FILL = 2'd0, CHK = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {FILL = 2'd0, WRITE = 2'd2, DONE = 2'd3} state_t;
`endif

  localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

  state_t         r_state;
  logic [255:0]   r_buffer;
  logic [4:0]     r_byteCnt;
  logic [7:0]     r_wordIdx;
  logic [7:0]     r_ramAddress;
  logic           r_inReady;
  logic           r_ramWren;
  logic           r_loadDone;
  logic           w_accept;
  logic           w_wordEnd;

  assign w_accept    = in_valid && r_inReady;
  // A word closes on its 32nd byte or on any earlier byte flagged in_last.
  assign w_wordEnd   = (r_byteCnt == 5'd31) || in_last;

  assign in_ready    = r_inReady;
  assign ram_address = r_ramAddress;
  assign ram_data    = r_buffer;
  assign ram_wren    = r_ramWren;
  assign load_done   = r_loadDone;

`ifdef LOADER_CHECKSUM_EN
  logic       r_chkErr;
  logic [7:0] w_checksum;

  // XOR over the whole buffer; zero-filled bytes contribute nothing.
  always_comb begin
    w_checksum = '0;
    for (int k = 0; k < 32; k++) begin
      w_checksum = w_checksum ^ r_buffer[8*k +: 8];
    end
  end

  assign chk_err = r_chkErr;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_buffer     <= '0;
      r_byteCnt    <= '0;
      r_wordIdx    <= '0;
      r_ramAddress <= BASE_ADDR;
      r_inReady    <= 1'b0;
      r_ramWren    <= 1'b0;
      r_loadDone   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chkErr     <= 1'b0;
`endif
    end else begin
      r_ramWren <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chkErr  <= 1'b0;
`endif
      case (r_state)
        // in_ready is forced high here so the first cycle after reset
        // (where it is still low) opens the handshake.
        FILL: begin
          r_inReady <= 1'b1;
          if (w_accept) begin
            r_buffer[{r_byteCnt, 3'b000} +: 8] <= in_data;
            r_byteCnt <= r_byteCnt + 5'd1;
            if (w_wordEnd) begin
`ifdef LOADER_CHECKSUM_EN
              r_state   <= CHK;
`else
              r_state   <= WRITE;
              r_ramWren <= 1'b1;
              r_inReady <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // A bad checksum throws the word away and refills the same slot.
        CHK: begin
          if (w_accept) begin
            if (in_data == w_checksum) begin
              r_state   <= WRITE;
              r_ramWren <= 1'b1;
              r_inReady <= 1'b0;
            end else begin
              r_chkErr  <= 1'b1;
              r_buffer  <= '0;
              r_byteCnt <= '0;
              r_state   <= FILL;
            end
          end
        end
`endif
        WRITE: begin
          if (r_wordIdx == LAST_IDX) begin
            r_state    <= DONE;
            r_loadDone <= 1'b1;
          end else begin
            r_wordIdx    <= r_wordIdx + 8'd1;
            r_ramAddress <= r_ramAddress + 8'd1;
            r_buffer     <= '0;
            r_byteCnt    <= '0;
            r_inReady    <= 1'b1;
            r_state      <= FILL;
          end
        end
        DONE: begin
          if (restart) begin
            r_wordIdx    <= '0;
            r_ramAddress <= BASE_ADDR;
            r_buffer     <= '0;
            r_byteCnt    <= '0;
            r_loadDone   <= 1'b0;
            r_inReady    <= 1'b1;
            r_state      <= FILL;
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

endmodule
